ps2_packet_decoder: RTL and testbench

//  Assembles the 3-byte PS/2 mouse movement packet from the byte-level PS/2 receiver into
//  9-bit two's-complement X/Y deltas, button state and overflow flags. Sits between the
//  PS/2 serial receiver and the ariphmetic stage, driving its x_axis/y_axis inputs directly.

---
 rtl/ps2_packet_decoder_if.sv | 26 ++
 rtl/ps2_packet_decoder.sv | 146 ++++++++++++++
 tb/tb_ps2_packet_decoder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_packet_decoder_if.sv
// Byte stream from the PS/2 receiver in, assembled mouse packet out.
// Signal prefixes are seen from the decoder's side: i_ = into the decoder, o_ = out of it.
interface ps2_packet_decoder_if;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       i_rx_err;
    logic [8:0] o_x_axis;
    logic [8:0] o_y_axis;
    logic [2:0] o_btn;
    logic       o_x_ovf;
    logic       o_y_ovf;
    logic       o_pkt_valid;
    logic       o_sync_err;

    // master: feeds bytes in and observes the packet (receiver/bench side).
    // slave: the decoder itself.
    modport master (
        output i_rx_data, i_rx_valid, i_rx_err,
        input  o_x_axis, o_y_axis, o_btn, o_x_ovf, o_y_ovf, o_pkt_valid, o_sync_err
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_rx_err,
        output o_x_axis, o_y_axis, o_btn, o_x_ovf, o_y_ovf, o_pkt_valid, o_sync_err
    );
endinterface

// File: rtl/ps2_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets into 9-bit X/Y deltas, buttons and overflow flags,
// resynchronising on bad header bytes, receiver errors and inter-byte timeouts.
//
// state   | meaning
// WAIT_B0 | idle, waiting for a header byte with bit3 set; timer held at 0
// WAIT_B1 | header stored, waiting for X byte; timer running
// WAIT_B2 | X stored, waiting for Y byte; timer running
module ps2_packet_decoder #(
    parameter int TIMEOUT_CYCLES = 100_000,
    parameter bit SAT_ON_OVF     = 1'b1,
    parameter int CNT_W          = 17
) (
    input  logic i_clk,
    input  logic i_rst,
    ps2_packet_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_n;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_n;
    logic [6:0]       r_hdr;    // header byte minus bit3: {y_ovf, x_ovf, y_sign, x_sign, btn[2:0]}
    logic [7:0]       r_b1;
    logic [8:0]       r_x_axis;
    logic [8:0]       r_y_axis;
    logic [2:0]       r_btn;
    logic             r_x_ovf;
    logic             r_y_ovf;
    logic             r_pkt_valid;
    logic             r_sync_err;

    logic             w_ld_b0;
    logic             w_ld_b1;
    logic             w_assemble;
    logic             w_sync_err;
    logic             w_timeout;

    // Saturation keeps the magnitude within 8 bits, so -256 is never produced.
    function automatic logic [8:0] axis_val(input logic sign, input logic ovf,
                                            input logic [7:0] mag);
        if (SAT_ON_OVF && ovf)
            return sign ? 9'h101 : 9'h0FF;
        return {sign, mag};
    endfunction

    assign w_timeout = (r_timer == TC_LAST);

    always_comb begin
        w_state_n  = r_state;
        w_ld_b0    = 1'b0;
        w_ld_b1    = 1'b0;
        w_assemble = 1'b0;
        w_sync_err = 1'b0;
        if (bus.i_rx_err) begin
            w_state_n  = WAIT_B0;
            w_sync_err = 1'b1;
        end else begin
            unique case (r_state)
                WAIT_B0: begin
                    if (bus.i_rx_valid) begin
                        if (bus.i_rx_data[3]) begin
                            w_ld_b0   = 1'b1;
                            w_state_n = WAIT_B1;
                        end else begin
                            w_sync_err = 1'b1;
                        end
                    end
                end
                WAIT_B1: begin
                    if (bus.i_rx_valid) begin
                        w_ld_b1   = 1'b1;
                        w_state_n = WAIT_B2;
                    end else if (w_timeout) begin
                        w_sync_err = 1'b1;
                        w_state_n  = WAIT_B0;
                    end
                end
                WAIT_B2: begin
                    if (bus.i_rx_valid) begin
                        w_assemble = 1'b1;
                        w_state_n  = WAIT_B0;
                    end else if (w_timeout) begin
                        w_sync_err = 1'b1;
                        w_state_n  = WAIT_B0;
                    end
                end
                default: w_state_n = WAIT_B0;
            endcase
        end
    end

    always_comb begin
        w_timer_n = r_timer + CNT_W'(1);
        if (w_state_n == WAIT_B0 || w_ld_b0 || w_ld_b1)
            w_timer_n = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= WAIT_B0;
            r_timer     <= '0;
            r_hdr       <= '0;
            r_b1        <= '0;
            r_x_axis    <= '0;
            r_y_axis    <= '0;
            r_btn       <= '0;
            r_x_ovf     <= 1'b0;
            r_y_ovf     <= 1'b0;
            r_pkt_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_timer     <= w_timer_n;
            r_pkt_valid <= w_assemble;
            r_sync_err  <= w_sync_err;
            if (w_ld_b0)
                r_hdr <= {bus.i_rx_data[7:4], bus.i_rx_data[2:0]};
            if (w_ld_b1)
                r_b1 <= bus.i_rx_data;
            if (w_assemble) begin
                r_x_axis <= axis_val(r_hdr[3], r_hdr[5], r_b1);
                r_y_axis <= axis_val(r_hdr[4], r_hdr[6], bus.i_rx_data);
                r_btn    <= r_hdr[2:0];
                r_x_ovf  <= r_hdr[5];
                r_y_ovf  <= r_hdr[6];
            end
        end
    end

    assign bus.o_x_axis    = r_x_axis;
    assign bus.o_y_axis    = r_y_axis;
    assign bus.o_btn       = r_btn;
    assign bus.o_x_ovf     = r_x_ovf;
    assign bus.o_y_ovf     = r_y_ovf;
    assign bus.o_pkt_valid = r_pkt_valid;
    assign bus.o_sync_err  = r_sync_err;

endmodule

// File: tb/tb_ps2_packet_decoder.sv
// Directed bench for ps2_packet_decoder: saturating and raw instances fed the same bytes,
// a packet table plus hand-written resync, timeout, error and reset sequences.
module tb_ps2_packet_decoder;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;

    int errors = 0;
    int checks = 0;
    int n_pkt  = 0;
    int n_sync = 0;
    int n_both = 0;

    always #5 clk = ~clk;

    ps2_packet_decoder_if bus();
    ps2_packet_decoder_if bus_raw();

    assign bus.i_rx_data      = rx_data;
    assign bus.i_rx_valid     = rx_valid;
    assign bus.i_rx_err       = rx_err;
    assign bus_raw.i_rx_data  = rx_data;
    assign bus_raw.i_rx_valid = rx_valid;
    assign bus_raw.i_rx_err   = rx_err;

    ps2_packet_decoder #(.TIMEOUT_CYCLES(TO), .SAT_ON_OVF(1'b1), .CNT_W(5)) u_dut (
        .i_clk(clk), .i_rst(rst), .bus(bus.slave)
    );

    ps2_packet_decoder #(.TIMEOUT_CYCLES(TO), .SAT_ON_OVF(1'b0), .CNT_W(5)) u_dut_raw (
        .i_clk(clk), .i_rst(rst), .bus(bus_raw.slave)
    );

    always @(negedge clk) begin
        if (bus.o_pkt_valid)                    n_pkt++;
        if (bus.o_sync_err)                     n_sync++;
        if (bus.o_pkt_valid && bus.o_sync_err)  n_both++;
    end

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic [8:0] x, y;
        logic [2:0] btn;
        logic       xo, yo;
        logic [8:0] rx, ry;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic [8:0] x, input logic [8:0] y,
                           input logic [2:0] btn, input logic xo, input logic yo);
        chk({nm, "_x"},    32'(bus.o_x_axis), 32'(x));
        chk({nm, "_y"},    32'(bus.o_y_axis), 32'(y));
        chk({nm, "_btn"},  32'(bus.o_btn),    32'(btn));
        chk({nm, "_xovf"}, 32'(bus.o_x_ovf),  32'(xo));
        chk({nm, "_yovf"}, 32'(bus.o_y_ovf),  32'(yo));
    endtask

    initial begin
        int s0, p0;

        vt[0] = '{8'h28, 8'h0A, 8'hF6, 9'h00A, 9'h1F6, 3'd0, 1'b0, 1'b0, 9'h00A, 9'h1F6};
        vt[1] = '{8'h19, 8'h05, 8'h00, 9'h105, 9'h000, 3'd1, 1'b0, 1'b0, 9'h105, 9'h000};
        vt[2] = '{8'h38, 8'hFF, 8'hFF, 9'h1FF, 9'h1FF, 3'd0, 1'b0, 1'b0, 9'h1FF, 9'h1FF};
        vt[3] = '{8'h0F, 8'h80, 8'h7F, 9'h080, 9'h07F, 3'd7, 1'b0, 1'b0, 9'h080, 9'h07F};
        vt[4] = '{8'h68, 8'h12, 8'h34, 9'h0FF, 9'h134, 3'd0, 1'b1, 1'b0, 9'h012, 9'h134};
        vt[5] = '{8'h58, 8'h00, 8'h00, 9'h101, 9'h000, 3'd0, 1'b1, 1'b0, 9'h100, 9'h000};
        vt[6] = '{8'hC8, 8'h00, 8'h00, 9'h0FF, 9'h0FF, 3'd0, 1'b1, 1'b1, 9'h000, 9'h000};

        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
        repeat (2) tick();
        chk_out("reset", 9'h000, 9'h000, 3'd0, 1'b0, 1'b0);
        chk("reset_pkt",  32'(bus.o_pkt_valid), 32'd0);
        chk("reset_sync", 32'(bus.o_sync_err),  32'd0);
        rst = 1'b0;
        tick();

        // Packet table, bytes back-to-back, result one clock after the last byte.
        for (int i = 0; i < 7; i++) begin
            send(vt[i].b0);
            send(vt[i].b1);
            chk($sformatf("v%0d_early_pkt", i), 32'(bus.o_pkt_valid), 32'd0);
            send(vt[i].b2);
            chk($sformatf("v%0d_pkt", i),  32'(bus.o_pkt_valid), 32'd1);
            chk($sformatf("v%0d_sync", i), 32'(bus.o_sync_err),  32'd0);
            chk_out($sformatf("v%0d", i), vt[i].x, vt[i].y, vt[i].btn, vt[i].xo, vt[i].yo);
            chk($sformatf("v%0d_raw_x", i), 32'(bus_raw.o_x_axis), 32'(vt[i].rx));
            chk($sformatf("v%0d_raw_y", i), 32'(bus_raw.o_y_axis), 32'(vt[i].ry));
            tick();
            chk($sformatf("v%0d_pkt_drop", i), 32'(bus.o_pkt_valid), 32'd0);
            chk_out($sformatf("v%0d_hold", i), vt[i].x, vt[i].y, vt[i].btn, vt[i].xo, vt[i].yo);
        end

        // Resync: two headerless bytes rejected, then a clean packet.
        tick();
        s0 = n_sync; p0 = n_pkt;
        send(8'h00);
        chk("resync_err0", 32'(bus.o_sync_err), 32'd1);
        send(8'h07);
        chk("resync_err1", 32'(bus.o_sync_err), 32'd1);
        chk_out("resync_hold", 9'h0FF, 9'h0FF, 3'd0, 1'b1, 1'b1);
        send(8'h08); send(8'h01); send(8'h02);
        chk("resync_pkt", 32'(bus.o_pkt_valid), 32'd1);
        chk_out("resync", 9'h001, 9'h002, 3'd0, 1'b0, 1'b0);
        repeat (2) tick();
        chk("resync_nsync", 32'(n_sync - s0), 32'd2);
        chk("resync_npkt",  32'(n_pkt - p0),  32'd1);

        // Timeout waiting for byte 2: fires exactly TO idle cycles after byte 1.
        s0 = n_sync; p0 = n_pkt;
        send(8'h08); send(8'h03);
        repeat (TO - 1) tick();
        chk("to_early", 32'(bus.o_sync_err), 32'd0);
        tick();
        chk("to_sync", 32'(bus.o_sync_err),  32'd1);
        chk("to_pkt",  32'(bus.o_pkt_valid), 32'd0);
        send(8'h08); send(8'h04); send(8'h05);
        chk("to_after_pkt", 32'(bus.o_pkt_valid), 32'd1);
        chk_out("to_after", 9'h004, 9'h005, 3'd0, 1'b0, 1'b0);
        repeat (2) tick();
        chk("to_nsync", 32'(n_sync - s0), 32'd1);
        chk("to_npkt",  32'(n_pkt - p0),  32'd1);

        // Byte arriving on the expiry cycle is accepted.
        s0 = n_sync;
        send(8'h08);
        repeat (TO - 1) tick();
        send(8'h06);
        chk("exp_sync", 32'(bus.o_sync_err), 32'd0);
        send(8'h07);
        chk("exp_pkt", 32'(bus.o_pkt_valid), 32'd1);
        chk_out("exp", 9'h006, 9'h007, 3'd0, 1'b0, 1'b0);
        repeat (2) tick();
        chk("exp_nsync", 32'(n_sync - s0), 32'd0);

        // rx_err mid-packet wins over a simultaneous rx_valid; following bytes lack bit3.
        s0 = n_sync; p0 = n_pkt;
        send(8'h08);
        rx_err = 1'b1; rx_valid = 1'b1; rx_data = 8'h09;
        tick();
        rx_err = 1'b0; rx_valid = 1'b0;
        chk("err_sync", 32'(bus.o_sync_err), 32'd1);
        send(8'h01);
        chk("err_rej1", 32'(bus.o_sync_err), 32'd1);
        send(8'h02);
        chk("err_rej2", 32'(bus.o_sync_err), 32'd1);
        repeat (2) tick();
        chk("err_nsync", 32'(n_sync - s0), 32'd3);
        chk("err_npkt",  32'(n_pkt - p0),  32'd0);
        chk_out("err_hold", 9'h006, 9'h007, 3'd0, 1'b0, 1'b0);

        // Reset mid-packet drops the partial packet and clears outputs.
        send(8'h08); send(8'h11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("mid_rst", 9'h000, 9'h000, 3'd0, 1'b0, 1'b0);
        chk("mid_rst_pkt",  32'(bus.o_pkt_valid), 32'd0);
        chk("mid_rst_sync", 32'(bus.o_sync_err),  32'd0);
        send(8'h09); send(8'h22); send(8'h33);
        chk("post_rst_pkt", 32'(bus.o_pkt_valid), 32'd1);
        chk_out("post_rst", 9'h022, 9'h033, 3'd1, 1'b0, 1'b0);
        repeat (2) tick();

        chk("pkt_and_sync_same_cycle", 32'(n_both), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
